// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_state_t;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for cla_seq_adder.
// Optional macro CLA_SEQ_OVF_EN adds the signed-overflow signal ovf.
interface cla_seq_adder_if #(
    parameter int unsigned WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice with fully expanded carries.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    // Generate/propagate terms and two-level lookahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum   = p ^ c[SLICE_W-1:0];
        cout  = c[4];
        c_msb = c[3];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit CLA slice, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on both sides.
// Optional macro CLA_SEQ_OVF_EN adds a registered signed-overflow output.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    cla_seq_adder_if.slave  bus
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH == 0) || ((WIDTH % SLICE_W) != 0)) begin : g_width_chk
        $error("cla_seq_adder: WIDTH must be a nonzero multiple of 4");
    end

    cla_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             last_pass;
    logic [IDX_W+1:0] ofs;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

    // Bit offset of the nibble handled this pass
    assign ofs       = {idx_q, 2'b00};
    assign last_pass = (idx_q == IDX_W'(NSLICE - 1));

    cla4_slice u_slice (
        .a     (a_q[ofs +: SLICE_W]),
        .b     (b_q[ofs +: SLICE_W]),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

`ifdef CLA_SEQ_OVF_EN
    logic ovf_q;

    // Signed overflow captured on the final pass, held with the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == RUN) && last_pass) begin
            ovf_q <= slice_cmsb ^ slice_cout;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = slice_cmsb;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[ofs +: SLICE_W] <= slice_sum;
                    carry_q               <= slice_cout;
                    idx_q                 <= idx_q + IDX_W'(1);
                    if (last_pass) begin
                        cout_q      <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: directed cases plus randomized traffic on a 16-bit
// and an 8-bit instance, checked against plain a+b+cin arithmetic.
// Build with CLA_SEQ_OVF_EN defined to also cover the ovf output.
module tb_cla_seq_adder;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    cla_seq_adder_if #(.WIDTH(16)) m16 ();
    cla_seq_adder_if #(.WIDTH(8))  m8  ();

    cla_seq_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(m16.slave));
    cla_seq_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(m8.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit w8);
        return w8 ? m8.in_ready : m16.in_ready;
    endfunction

    function automatic logic ov(input bit w8);
        return w8 ? m8.out_valid : m16.out_valid;
    endfunction

    function automatic logic bsy(input bit w8);
        return w8 ? m8.busy : m16.busy;
    endfunction

    function automatic logic [16:0] res(input bit w8);
        return w8 ? {8'd0, m8.cout, m8.sum} : {m16.cout, m16.sum};
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic c);
        if (w8) begin
            m8.in_valid = v; m8.a = av[7:0]; m8.b = bv[7:0]; m8.cin = c;
        end else begin
            m16.in_valid = v; m16.a = av; m16.b = bv; m16.cin = c;
        end
    endtask

    task automatic ordy(input bit w8, input logic r);
        if (w8) m8.out_ready = r;
        else    m16.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, latency check, optional stall with junk
    // in_valid traffic, then result check and handshake.
    task automatic run_op(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                          input logic c, input int stall);
        logic [16:0] exp;
        logic [16:0] held;
        int          n;
        if (w8) exp = 17'(av[7:0]) + 17'(bv[7:0]) + 17'(c);
        else    exp = 17'(av) + 17'(bv) + 17'(c);

        n = 0;
        while (!rdy(w8) && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(rdy(w8)), 32'd1);

        drive(w8, 1'b1, av, bv, c);
        tick();
        drive(w8, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        chk("in_ready_after_accept", 32'(rdy(w8)), 32'd0);

        n = 0;
        while (!ov(w8) && n < 50) begin
            tick();
            n++;
            drive(w8, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end
        chk("latency", 32'(n), w8 ? 32'd2 : 32'd4);
        chk("result", 32'(res(w8)), 32'(exp));
`ifdef CLA_SEQ_OVF_EN
        begin
            logic ovf_exp;
            logic ovf_obs;
            if (w8) ovf_exp = (av[7] == bv[7]) && (exp[7] != av[7]);
            else    ovf_exp = (av[15] == bv[15]) && (exp[15] != av[15]);
            ovf_obs = w8 ? m8.ovf : m16.ovf;
            chk("ovf", 32'(ovf_obs), 32'(ovf_exp));
        end
`endif

        held = res(w8);
        for (int i = 0; i < stall; i++) begin
            tick();
            drive(w8, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            chk("stall_result_stable", 32'(res(w8)), 32'(held));
            chk("stall_out_valid", 32'(ov(w8)), 32'd1);
            chk("stall_in_ready", 32'(rdy(w8)), 32'd0);
            chk("stall_busy", 32'(bsy(w8)), 32'd1);
        end

        ordy(w8, 1'b1);
        tick();
        drive(w8, 1'b0, 16'd0, 16'd0, 1'b0);
        ordy(w8, 1'b0);
        chk("out_valid_after_handshake", 32'(ov(w8)), 32'd0);
        chk("in_ready_after_handshake", 32'(rdy(w8)), 32'd1);
        chk("busy_after_handshake", 32'(bsy(w8)), 32'd0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clk  = 1'b0;
        rst  = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        ordy(1'b0, 1'b0);
        ordy(1'b1, 1'b0);

        // Reset state
        #2;
        chk("rst_in_ready", 32'(m16.in_ready), 32'd1);
        chk("rst_out_valid", 32'(m16.out_valid), 32'd0);
        chk("rst_sum", 32'(m16.sum), 32'd0);
        chk("rst_cout", 32'(m16.cout), 32'd0);
        chk("rst_busy", 32'(m16.busy), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        chk("rst_ovf", 32'(m16.ovf), 32'd0);
`endif
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 0);
        run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 0);
        run_op(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 5);

        // Reset in the middle of an operation aborts it
        while (!m16.in_ready) tick();
        drive(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(m16.out_valid), 32'd0);
        chk("abort_sum", 32'(m16.sum), 32'd0);
        chk("abort_in_ready", 32'(m16.in_ready), 32'd1);
        chk("abort_busy", 32'(m16.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 0);

`ifdef CLA_SEQ_OVF_EN
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 0);
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 0);
`endif

        // 8-bit boundary cases
        run_op(1'b1, 16'h00FF, 16'h0000, 1'b1, 1);
        run_op(1'b1, 16'h007F, 16'h0001, 1'b0, 0);

        // Randomized back-to-back traffic with random output stalls
        for (int i = 0; i < 1000; i++)
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        for (int i = 0; i < 300; i++)
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
